// File: rtl/ascon_perm_readout.sv
// ascon_perm_readout
// Captures the Ascon permutation result on perm_done and serves it to the CPU
// as WORDS x DW-bit words, most-significant word first, over a read-strobe /
// wait port. A control register handles rewind, discard and overrun clear, and a
// status register reports idx/empty/overrun/valid. drained pulses once the last
// word has been acked so the permutation FSM knows the buffer is free.
module ascon_perm_readout #(
  parameter int WORDS       = 10,
  parameter int DW          = 32,
  parameter bit STALL_EMPTY = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                perm_done,
  input  logic [WORDS*DW-1:0] perm_out,
  input  logic                reg_dat_re,
  output logic [DW-1:0]       reg_dat_do,
  output logic                reg_dat_wait,
  input  logic                reg_ctl_we,
  input  logic [DW-1:0]       reg_ctl_di,
  output logic [DW-1:0]       reg_sts_do,
  output logic                result_valid,
  output logic                drained
);

  // Word-select width for the buffer; idx itself is fixed at 4 bits, so
  // WORDS must stay at or below 16.
  localparam int SW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t                     state_q, state_d;
  // Word k of the result lives at index WORDS-1-k (perm_out is MSW first).
  logic [WORDS-1:0][DW-1:0]   rbuf_q, rbuf_d;
  logic [3:0]                 idx_q, idx_d;
  logic                       ack_q, ack_d;
  logic                       ovr_q, ovr_d;
  logic [DW-1:0]              do_q, do_d;
  logic                       drn_q, drn_d;

  logic                       rd_req, ack_fire, ack_full, last_w, ovr_set;
  logic                       ctl_rew, ctl_dis, ctl_clr;
  logic [SW-1:0]              sel;
  logic [DW-1:0]              cur_word;
  logic                       unused_ctl;

  assign unused_ctl = ^reg_ctl_di[DW-1:3];

  // A pending read is one with the strobe up and no ack this cycle; ack_q
  // masks it so an ack never repeats on consecutive cycles.
  assign rd_req   = reg_dat_re & ~ack_q;
  assign ack_fire = rd_req & ((state_q == S_FULL) | ~STALL_EMPTY);
  assign ack_full = ack_fire & (state_q == S_FULL);
  assign last_w   = (idx_q == 4'(WORDS-1));

  assign ctl_rew  = reg_ctl_we & reg_ctl_di[0];
  assign ctl_dis  = reg_ctl_we & reg_ctl_di[1];
  assign ctl_clr  = reg_ctl_we & reg_ctl_di[2];

  // A new result landing on unread data is an overrun, except when it coincides
  // with the ack of the final word (the old result is fully consumed), or when
  // idx==0 with an ack still in flight.
  assign ovr_set  = perm_done & (state_q == S_FULL)
                  & ((idx_q != 4'd0) | ~ack_q)
                  & ~(ack_full & last_w);

  assign sel      = SW'(WORDS-1) - SW'(idx_q);
  assign cur_word = rbuf_q[sel];

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_EMPTY;
    else         state_q <= state_d;
  end

  // Next state: last-word ack and discard empty the buffer, capture refills it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (perm_done) state_d = S_FULL;
      S_FULL:  if (ack_full && last_w) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (ctl_dis)   state_d = S_EMPTY;
    if (perm_done) state_d = S_FULL;
  end

  // Datapath next-state: read index, ack, read data, overrun, buffer
  always_comb begin
    idx_d  = idx_q;
    ack_d  = ack_fire;
    do_d   = do_q;
    drn_d  = ack_full & last_w;
    ovr_d  = ovr_q | ovr_set;
    rbuf_d = rbuf_q;
    if (ack_fire) do_d = (state_q == S_FULL) ? cur_word : '0;
    if (ack_full) idx_d = last_w ? 4'd0 : idx_q + 4'd1;
    if (ctl_rew || ctl_dis || perm_done) idx_d = 4'd0;
    if (ctl_clr) ovr_d = 1'b0;
    if (perm_done) rbuf_d = perm_out;
  end

  // Datapath registers; reset drops any in-flight ack immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rbuf_q <= '0;
      idx_q  <= 4'd0;
      ack_q  <= 1'b0;
      ovr_q  <= 1'b0;
      do_q   <= '0;
      drn_q  <= 1'b0;
    end else begin
      rbuf_q <= rbuf_d;
      idx_q  <= idx_d;
      ack_q  <= ack_d;
      ovr_q  <= ovr_d;
      do_q   <= do_d;
      drn_q  <= drn_d;
    end
  end

  // Outputs: wait is combinational on the strobe, everything else registered
  always_comb begin
    reg_dat_wait = rd_req;
    reg_dat_do   = do_q;
    drained      = drn_q;
    result_valid = (state_q == S_FULL);
    reg_sts_do   = {{(DW-12){1'b0}}, idx_q, 5'b0,
                    (state_q == S_EMPTY), ovr_q, (state_q == S_FULL)};
  end

endmodule

// File: tb/tb_ascon_perm_readout.sv
// Bench for ascon_perm_readout: directed table and corner sequences on a
// STALL_EMPTY=1 instance, plus randomized traffic on both STALL_EMPTY variants
// checked against a word-array reference model.
module tb_ascon_perm_readout;
  localparam int WORDS = 10;
  localparam int DW    = 32;
  localparam int SW    = WORDS*DW;

  logic          clk = 1'b0, resetn = 1'b0, perm_done = 1'b0;
  logic          reg_dat_re = 1'b0, reg_ctl_we = 1'b0;
  logic [SW-1:0] perm_out = '0;
  logic [DW-1:0] reg_ctl_di = '0;
  logic [DW-1:0] do1, sts1, do0, sts0;
  logic          wt1, wt0, vl1, vl0, dr1, dr0;
  int            n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  ascon_perm_readout #(.WORDS(WORDS), .DW(DW), .STALL_EMPTY(1'b1)) dut (
    .clk(clk), .resetn(resetn), .perm_done(perm_done), .perm_out(perm_out),
    .reg_dat_re(reg_dat_re), .reg_dat_do(do1), .reg_dat_wait(wt1),
    .reg_ctl_we(reg_ctl_we), .reg_ctl_di(reg_ctl_di), .reg_sts_do(sts1),
    .result_valid(vl1), .drained(dr1));

  ascon_perm_readout #(.WORDS(WORDS), .DW(DW), .STALL_EMPTY(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .perm_done(perm_done), .perm_out(perm_out),
    .reg_dat_re(reg_dat_re), .reg_dat_do(do0), .reg_dat_wait(wt0),
    .reg_ctl_we(reg_ctl_we), .reg_ctl_di(reg_ctl_di), .reg_sts_do(sts0),
    .result_valid(vl0), .drained(dr0));

  // Reference model: result as a plain word array (index = word number)
  typedef struct {
    logic [WORDS-1:0][DW-1:0] w;
    int            idx;
    bit            full, ack, ovr, drn;
    logic [DW-1:0] dout;
  } mdl_t;

  typedef struct {
    logic [DW-1:0] exp_do;
    logic          exp_drn;
    logic [DW-1:0] exp_sts;
  } rvec_t;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] pat(input logic [DW-1:0] base);
    logic [SW-1:0] p;
    for (int k = 0; k < WORDS; k++) p[SW-1-k*DW -: DW] = base + DW'(k);
    return p;
  endfunction

  function automatic mdl_t mdl_init();
    mdl_t m;
    m.w = '0; m.idx = 0; m.full = 0; m.ack = 0; m.ovr = 0; m.drn = 0; m.dout = '0;
    return m;
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit stall, input bit re, input bit done,
                                input logic [SW-1:0] po, input bit we, input logic [DW-1:0] di);
    mdl_t n;
    bit   take, lastw;
    n     = m;
    take  = re && !m.ack && (m.full || !stall);
    lastw = take && m.full && (m.idx == WORDS-1);
    n.ack = take;
    n.drn = lastw;
    if (take) n.dout = m.full ? m.w[m.idx] : '0;
    if (take && m.full) begin
      if (lastw) begin n.idx = 0; n.full = 0; end
      else n.idx = m.idx + 1;
    end
    if (we && di[0]) n.idx = 0;
    if (we && di[1]) begin n.full = 0; n.idx = 0; end
    if (done) begin
      if (m.full && !lastw && (m.idx != 0 || !m.ack)) n.ovr = 1;
      for (int k = 0; k < WORDS; k++) n.w[k] = po[SW-1-k*DW -: DW];
      n.full = 1; n.idx = 0;
    end
    if (we && di[2]) n.ovr = 0;
    return n;
  endfunction

  function automatic logic [DW-1:0] mdl_sts(input mdl_t m);
    logic [DW-1:0] s;
    s = '0;
    s[11:8] = 4'(m.idx);
    s[2] = !m.full; s[1] = m.ovr; s[0] = m.full;
    return s;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; perm_done = 1'b0; reg_dat_re = 1'b0; reg_ctl_we = 1'b0; reg_ctl_di = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic capture(input logic [SW-1:0] p);
    perm_out = p; perm_done = 1'b1;
    @(negedge clk);
    perm_done = 1'b0;
  endtask

  task automatic ctl(input logic [2:0] v);
    reg_ctl_we = 1'b1; reg_ctl_di = {29'b0, v};
    @(negedge clk);
    reg_ctl_we = 1'b0; reg_ctl_di = '0;
  endtask

  // One CPU read: strobe until wait drops, take data in the ack cycle
  task automatic rd(output logic [DW-1:0] d, output int nw, output logic drn,
                    output logic [DW-1:0] sts, input int budget);
    reg_dat_re = 1'b1; nw = 0;
    #1;
    while (wt1 && nw < budget) begin nw++; @(negedge clk); #1; end
    d = do1; drn = dr1; sts = sts1;
    reg_dat_re = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rvec_t         tv[WORDS];
    logic [DW-1:0] d, s;
    logic          drn;
    int            nw;
    mdl_t          m1, m0;
    bit            hold;

    for (int k = 0; k < WORDS; k++) begin
      tv[k].exp_do  = DW'(k+1);
      tv[k].exp_drn = (k == WORDS-1);
      tv[k].exp_sts = (k == WORDS-1) ? 32'h4 : ((DW'(k+1) << 8) | 32'h1);
    end

    // Reset state
    do_reset();
    chk("rst_do", do1, 0);         chk("rst_sts", sts1, 32'h4);
    chk("rst_valid", 32'(vl1), 0); chk("rst_drained", 32'(dr1), 0);
    chk("rst_wait", 32'(wt1), 0);  chk("rst_sts_s0", sts0, 32'h4);

    // Full drain of a captured result, word k = k+1
    capture(pat(32'h1));
    chk("cap_valid", 32'(vl1), 1); chk("cap_sts", sts1, 32'h1);
    for (int k = 0; k < WORDS; k++) begin
      rd(d, nw, drn, s, 8);
      chk($sformatf("drain_do%0d", k), d, tv[k].exp_do);
      chk($sformatf("drain_wait%0d", k), nw, 1);
      chk($sformatf("drain_drn%0d", k), 32'(drn), 32'(tv[k].exp_drn));
      chk($sformatf("drain_sts%0d", k), s, tv[k].exp_sts);
    end
    chk("drain_valid_after", 32'(vl1), 0);
    chk("drain_drn_after", 32'(dr1), 0);
    chk("drain_sts_after", sts1, 32'h4);

    // Read while empty: capture 3 cycles after the strobe; wait covers the
    // three empty cycles, the capture cycle and the cycle that fires the ack
    do_reset();
    fork
      begin
        repeat (3) @(negedge clk);
        perm_out = pat(32'h11); perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
      end
    join_none
    reg_dat_re = 1'b1;
    #1;
    chk("stall_wait0", 32'(wt1), 1); chk("nostall_wait0", 32'(wt0), 1);
    nw = 1;
    @(negedge clk); #1;
    chk("nostall_ack_wait", 32'(wt0), 0); chk("nostall_ack_do", do0, 0);
    chk("nostall_sts", sts0, 32'h4);
    while (wt1 && nw < 20) begin nw++; @(negedge clk); #1; end
    chk("stall_cycles", nw, 5);
    chk("stall_do", do1, 32'h11);
    reg_dat_re = 1'b0;
    @(negedge clk);

    // Overrun after partial read, then clear
    do_reset();
    capture(pat(32'h1));
    for (int k = 0; k < 3; k++) begin
      rd(d, nw, drn, s, 8);
      chk($sformatf("ovr_pre_do%0d", k), d, DW'(k+1));
    end
    capture(pat(32'hA0));
    chk("ovr_sts", sts1, 32'h3);
    rd(d, nw, drn, s, 8);
    chk("ovr_new_do", d, 32'hA0);
    chk("ovr_ack_sts", s, 32'h103);
    ctl(3'b100);
    chk("ovr_clr_sts", sts1, 32'h101);

    // Capture on the same edge as the last-word ack
    do_reset();
    capture(pat(32'h1));
    for (int k = 0; k < WORDS-1; k++) rd(d, nw, drn, s, 8);
    perm_out = pat(32'hA0); perm_done = 1'b1; reg_dat_re = 1'b1;
    #1;
    chk("sim_wait", 32'(wt1), 1);
    @(negedge clk);
    perm_done = 1'b0;
    #1;
    chk("sim_do", do1, 32'hA);
    chk("sim_drained", 32'(dr1), 1);
    chk("sim_valid", 32'(vl1), 1);
    chk("sim_sts", sts1, 32'h1);
    reg_dat_re = 1'b0;
    @(negedge clk);
    rd(d, nw, drn, s, 8);
    chk("sim_next_do", d, 32'hA0);

    // Rewind then discard
    do_reset();
    capture(pat(32'h1));
    for (int k = 0; k < 4; k++) rd(d, nw, drn, s, 8);
    ctl(3'b001);
    rd(d, nw, drn, s, 8);
    chk("rewind_do", d, 32'h1);
    ctl(3'b010);
    chk("discard_valid", 32'(vl1), 0);
    chk("discard_sts", sts1, 32'h4);
    rd(d, nw, drn, s, 6);
    chk("discard_stall", nw, 6);

    // Reset during a wait cycle
    do_reset();
    capture(pat(32'h1));
    rd(d, nw, drn, s, 8);
    chk("mid_pre_do", do1, 32'h1);
    reg_dat_re = 1'b1;
    #1;
    chk("mid_wait", 32'(wt1), 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_do", do1, 0);
    chk("mid_rst_sts", sts1, 32'h4);
    chk("mid_rst_wait", 32'(wt1), 1);
    reg_dat_re = 1'b0;
    #1;
    chk("mid_rst_wait_lo", 32'(wt1), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    capture(pat(32'hA0));
    rd(d, nw, drn, s, 8);
    chk("mid_after_do", d, 32'hA0);

    // Randomized traffic on both variants against the model
    do_reset();
    m1 = mdl_init(); m0 = mdl_init();
    for (int c = 0; c < 3000; c++) begin
      hold = reg_dat_re && (!m1.ack || !m0.ack);
      reg_dat_re = hold ? 1'b1 : ($urandom_range(0, 1) == 1);
      perm_done  = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < WORDS; k++) perm_out[k*DW +: DW] = $urandom;
      reg_ctl_we = ($urandom_range(0, 15) == 0);
      reg_ctl_di = $urandom;
      @(posedge clk);
      m1 = step(m1, 1'b1, reg_dat_re, perm_done, perm_out, reg_ctl_we, reg_ctl_di);
      m0 = step(m0, 1'b0, reg_dat_re, perm_done, perm_out, reg_ctl_we, reg_ctl_di);
      @(negedge clk);
      chk("rnd_do_s1",   do1, m1.dout);
      chk("rnd_wait_s1", 32'(wt1), 32'(reg_dat_re && !m1.ack));
      chk("rnd_sts_s1",  sts1, mdl_sts(m1));
      chk("rnd_drn_s1",  32'(dr1), 32'(m1.drn));
      chk("rnd_vld_s1",  32'(vl1), 32'(m1.full));
      chk("rnd_do_s0",   do0, m0.dout);
      chk("rnd_wait_s0", 32'(wt0), 32'(reg_dat_re && !m0.ack));
      chk("rnd_sts_s0",  sts0, mdl_sts(m0));
      chk("rnd_drn_s0",  32'(dr0), 32'(m0.drn));
      chk("rnd_vld_s0",  32'(vl0), 32'(m0.full));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
